// File: rtl/programmable_tt_eval_pkg.sv
// Shared types and helpers for the programmable truth-table evaluator.
//   tt_state_e : controller states (RUN evaluates, LOAD shifts in a new table)
//   tt_width() : number of table entries for a given input count
package programmable_tt_eval_pkg;

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_LOAD = 1'b1
   } tt_state_e;

   // Table width is 2**n_in entries.
   function automatic int unsigned tt_width(input int unsigned n_in);
      return 32'(1) << n_in;
   endfunction

endpackage

// File: rtl/programmable_tt_eval_if.sv
// Configuration, evaluation and result bus of programmable_tt_eval.
//   cfg_*      : serial truth-table load (start/abort/valid/bit in, ready/done out)
//   in_*       : input vector handshake (valid/vec in, ready out)
//   out_*      : result handshake (valid/bit out, ready in)
//   eval_count : saturating count of accepted evaluations
// master drives the requests, slave is the evaluator.
interface programmable_tt_eval_if #(
   parameter int unsigned N_IN  = 4,
   parameter int unsigned CNT_W = 16
);
   logic             cfg_start;
   logic             cfg_abort;
   logic             cfg_valid;
   logic             cfg_bit;
   logic             cfg_ready;
   logic             cfg_done;
   logic             in_valid;
   logic [N_IN-1:0]  in_vec;
   logic             in_ready;
   logic             out_valid;
   logic             out_bit;
   logic             out_ready;
   logic [CNT_W-1:0] eval_count;

   modport master (
      output cfg_start, cfg_abort, cfg_valid, cfg_bit, in_valid, in_vec, out_ready,
      input  cfg_ready, cfg_done, in_ready, out_valid, out_bit, eval_count
   );

   modport slave (
      input  cfg_start, cfg_abort, cfg_valid, cfg_bit, in_valid, in_vec, out_ready,
      output cfg_ready, cfg_done, in_ready, out_valid, out_bit, eval_count
   );
endinterface

// File: rtl/tt_shift_loader.sv
// Serial shadow loader: collects a truth table MSB first.
//   clk, rst   : clock, async active-high reset
//   clear      : drop any partial table and restart at bit 0
//   shift_en   : accept bit_in this cycle
//   bit_in     : serial table bit
//   at_last_c  : next accepted bit completes the table
//   table_c    : full table formed by the stored bits plus bit_in
module tt_shift_loader #(
   parameter int unsigned TT_W = 16
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            clear,
   input  logic            shift_en,
   input  logic            bit_in,
   output logic            at_last_c,
   output logic [TT_W-1:0] table_c
);
   localparam int unsigned IDX_W = $clog2(TT_W);

   // Only TT_W-1 bits need storage; the final bit is taken straight from bit_in.
   logic [TT_W-2:0]  shadow_q;
   logic [IDX_W-1:0] idx_q;

   assign at_last_c = (idx_q == IDX_W'(TT_W - 1));
   assign table_c   = {shadow_q, bit_in};

   // Shift register and bit index; both restart after a completed table.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_q <= '0;
         idx_q    <= '0;
      end else if (clear) begin
         shadow_q <= '0;
         idx_q    <= '0;
      end else if (shift_en) begin
         if (at_last_c) begin
            shadow_q <= '0;
            idx_q    <= '0;
         end else begin
            shadow_q <= {shadow_q[TT_W-3:0], bit_in};
            idx_q    <= idx_q + IDX_W'(1);
         end
      end
   end
endmodule

// File: rtl/programmable_tt_eval.sv
// Programmable N_IN-input boolean function evaluator.
//   clk, rst : clock, async active-high reset
//   bus      : programmable_tt_eval_if slave (cfg load, input vector, result, eval_count)
// In RUN each accepted in_vec yields active_table[in_vec] one cycle later.
// In LOAD a new table is shifted in and committed atomically on its last bit.
module programmable_tt_eval
   import programmable_tt_eval_pkg::*;
#(
   parameter int unsigned                N_IN     = 4,
   parameter logic [tt_width(N_IN)-1:0] TT_RESET = 16'hE93A,
   parameter int unsigned                CNT_W    = 16
)(
   input  logic                    clk,
   input  logic                    rst,
   programmable_tt_eval_if.slave   bus
);
   localparam int unsigned TT_W = tt_width(N_IN);

   localparam logic [0:0] RUN  = ST_RUN;
   localparam logic [0:0] LOAD = ST_LOAD;

   logic [0:0]       state_q;
   logic [0:0]       state_d;
   logic [TT_W-1:0]  active_q;
   logic             cfg_done_q;
   logic             out_valid_q;
   logic             out_bit_q;
   logic [CNT_W-1:0] cnt_q;

   logic             loader_clear_c;
   logic             shift_en_c;
   logic             commit_c;
   logic             last_c;
   logic [TT_W-1:0]  table_c;
   logic             in_ready_c;
   logic             accept_c;

   tt_shift_loader #(
      .TT_W (TT_W)
   ) u_loader (
      .clk       (clk),
      .rst       (rst),
      .clear     (loader_clear_c),
      .shift_en  (shift_en_c),
      .bit_in    (bus.cfg_bit),
      .at_last_c (last_c),
      .table_c   (table_c)
   );

   // Next-state and load control; abort wins over a bit offered in the same cycle.
   always_comb begin
      state_d        = state_q;
      loader_clear_c = 1'b0;
      shift_en_c     = 1'b0;
      commit_c       = 1'b0;
      case (state_q)
         RUN: begin
            if (bus.cfg_start) begin
               state_d        = LOAD;
               loader_clear_c = 1'b1;
            end
         end
         LOAD: begin
            if (bus.cfg_abort) begin
               state_d        = RUN;
               loader_clear_c = 1'b1;
            end else if (bus.cfg_valid) begin
               shift_en_c = 1'b1;
               if (last_c) begin
                  commit_c = 1'b1;
                  state_d  = RUN;
               end
            end
         end
         default: state_d = RUN;
      endcase
   end

   // State, active table and commit pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= RUN;
         active_q   <= TT_RESET;
         cfg_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cfg_done_q <= commit_c;
         if (commit_c) begin
            active_q <= table_c;
         end
      end
   end

   // Output stage accepts whenever its register is empty or being drained.
   assign in_ready_c = (state_q == RUN) && (!out_valid_q || bus.out_ready);
   assign accept_c   = bus.in_valid && in_ready_c;

   // Single-entry result register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_bit_q   <= 1'b0;
      end else if (accept_c) begin
         out_valid_q <= 1'b1;
         out_bit_q   <= active_q[bus.in_vec];
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   // Saturating evaluation counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (accept_c && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign bus.cfg_ready  = (state_q == LOAD);
   assign bus.cfg_done   = cfg_done_q;
   assign bus.in_ready   = in_ready_c;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_bit    = out_bit_q;
   assign bus.eval_count = cnt_q;
endmodule

// File: tb/tb_programmable_tt_eval.sv
// Self-checking bench for programmable_tt_eval: table-driven vectors, a result
// scoreboard fed by the driver and drained by a negedge monitor, and directed
// sequences for load, abort, stall, reset-during-load and counter saturation.
module tb_programmable_tt_eval;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   programmable_tt_eval_if #(.N_IN(4), .CNT_W(16)) ifc ();
   programmable_tt_eval_if #(.N_IN(2), .CNT_W(2))  ifc2 ();

   programmable_tt_eval #(
      .N_IN     (4),
      .TT_RESET (16'hE93A),
      .CNT_W    (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   programmable_tt_eval #(
      .N_IN     (2),
      .TT_RESET (4'b0110),
      .CNT_W    (2)
   ) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (ifc2.slave)
   );

   typedef struct {
      logic [3:0] vec;
      logic       exp;
   } vec_t;

   vec_t        vt [4];
   int          checks   = 0;
   int          failures = 0;
   logic        exp_q [$];
   bit          pend_lat = 1'b0;
   int          done_cnt = 0;
   int          cnt_model = 0;
   logic [15:0] model_tt;
   logic [3:0]  tt2_model;
   int          vecs2 [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: latency, result order/value, commit pulses, accept count.
   always @(negedge clk) begin
      if (rst) begin
         pend_lat = 1'b0;
      end else begin
         if (ifc.cfg_done) done_cnt++;
         if (pend_lat) chk("latency_out_valid", 32'(ifc.out_valid), 32'd1);
         pend_lat = ifc.in_valid && ifc.in_ready;
         if (pend_lat) cnt_model++;
         if (ifc.out_valid && ifc.out_ready) begin
            if (exp_q.size() == 0) chk("spurious_out_valid", 32'(ifc.out_valid), 32'd0);
            else chk("out_bit", 32'(ifc.out_bit), 32'(exp_q.pop_front()));
         end
      end
   end

   // Offer one vector; push its expected result when the DUT accepts it.
   task automatic send(input logic [3:0] v, input logic e);
      int n = 0;
      ifc.in_valid = 1'b1;
      ifc.in_vec   = v;
      @(negedge clk);
      while (!ifc.in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!ifc.in_ready) chk("in_ready_timeout", 32'(ifc.in_ready), 32'd1);
      else exp_q.push_back(e);
      @(posedge clk);
      #1;
      ifc.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("out_valid_cleared", 32'(ifc.out_valid), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_begin();
      ifc.cfg_start = 1'b1;
      @(posedge clk);
      #1;
      ifc.cfg_start = 1'b0;
      #3;
      chk("cfg_ready_in_load", 32'(ifc.cfg_ready), 32'd1);
      chk("in_ready_in_load", 32'(ifc.in_ready), 32'd0);
   endtask

   task automatic shift_bit(input logic b);
      ifc.cfg_valid = 1'b1;
      ifc.cfg_bit   = b;
      @(posedge clk);
      #1;
      ifc.cfg_valid = 1'b0;
   endtask

   task automatic load_table(input logic [15:0] val, input bit poke_start);
      int d0 = done_cnt;
      cfg_begin();
      for (int i = 15; i >= 0; i--) begin
         if (poke_start && i == 8) ifc.cfg_start = 1'b1;
         shift_bit(val[i]);
         ifc.cfg_start = 1'b0;
      end
      #3;
      chk("cfg_done_pulse", 32'(ifc.cfg_done), 32'd1);
      chk("cfg_ready_after_commit", 32'(ifc.cfg_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("cfg_done_single", 32'(ifc.cfg_done), 32'd0);
      chk("cfg_done_count", 32'(done_cnt), 32'(d0 + 1));
      model_tt = val;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int d0;
      vt[0] = '{4'd0,  1'b0};
      vt[1] = '{4'd1,  1'b1};
      vt[2] = '{4'd3,  1'b1};
      vt[3] = '{4'd15, 1'b1};
      tt2_model = 4'b0110;
      vecs2 = '{1, 3, 1, 2, 0};
      model_tt = 16'hE93A;

      ifc.cfg_start = 1'b0; ifc.cfg_abort = 1'b0; ifc.cfg_valid = 1'b0; ifc.cfg_bit = 1'b0;
      ifc.in_valid  = 1'b0; ifc.in_vec    = '0;   ifc.out_ready = 1'b1;
      ifc2.cfg_start = 1'b0; ifc2.cfg_abort = 1'b0; ifc2.cfg_valid = 1'b0; ifc2.cfg_bit = 1'b0;
      ifc2.in_valid  = 1'b0; ifc2.in_vec    = '0;   ifc2.out_ready = 1'b1;

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #3;
      chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
      chk("rst_out_bit", 32'(ifc.out_bit), 32'd0);
      chk("rst_eval_count", 32'(ifc.eval_count), 32'd0);
      chk("rst_cfg_ready", 32'(ifc.cfg_ready), 32'd0);
      chk("rst_cfg_done", 32'(ifc.cfg_done), 32'd0);
      @(posedge clk);
      #1;

      // Reset table, back-to-back vectors.
      for (int i = 0; i < 4; i++) send(vt[i].vec, vt[i].exp);
      drain();
      chk("eval_count_after_4", 32'(ifc.eval_count), 32'd4);

      // Output stall: result holds, input blocked, released in the same cycle.
      ifc.out_ready = 1'b0;
      send(4'd1, 1'b1);
      ifc.in_valid = 1'b1;
      ifc.in_vec   = 4'd2;
      repeat (3) begin
         @(negedge clk);
         chk("stall_out_valid", 32'(ifc.out_valid), 32'd1);
         chk("stall_out_bit", 32'(ifc.out_bit), 32'd1);
         chk("stall_in_ready", 32'(ifc.in_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      ifc.out_ready = 1'b1;
      #1;
      chk("release_in_ready", 32'(ifc.in_ready), 32'd1);
      exp_q.push_back(model_tt[2]);
      @(posedge clk);
      #1;
      ifc.in_valid = 1'b0;
      drain();

      // Abort after 5 bits, with a bit offered alongside the abort.
      d0 = done_cnt;
      cfg_begin();
      for (int i = 15; i >= 11; i--) shift_bit(1'b1);
      ifc.cfg_abort = 1'b1;
      ifc.cfg_valid = 1'b1;
      ifc.cfg_bit   = 1'b1;
      @(posedge clk);
      #1;
      ifc.cfg_abort = 1'b0;
      ifc.cfg_valid = 1'b0;
      #3;
      chk("abort_cfg_ready", 32'(ifc.cfg_ready), 32'd0);
      chk("abort_in_ready", 32'(ifc.in_ready), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      chk("abort_no_done", 32'(done_cnt), 32'(d0));
      send(4'd0, 1'b0);
      send(4'd1, 1'b1);
      drain();

      // Full load of 0x8000 with a stray cfg_start mid-load, then a stray abort in RUN.
      load_table(16'h8000, 1'b1);
      ifc.cfg_abort = 1'b1;
      @(posedge clk);
      #1;
      ifc.cfg_abort = 1'b0;
      chk("abort_in_run_ignored", 32'(ifc.cfg_ready), 32'd0);
      for (int v = 0; v < 16; v++) send(4'(v), (v == 15) ? 1'b1 : 1'b0);
      drain();

      // A held result survives a table reload with its old-table value.
      ifc.out_ready = 1'b0;
      send(4'd15, model_tt[15]);
      load_table(16'h0000, 1'b0);
      chk("held_out_valid", 32'(ifc.out_valid), 32'd1);
      chk("held_out_bit", 32'(ifc.out_bit), 32'd1);
      ifc.out_ready = 1'b1;
      send(4'd15, model_tt[15]);
      drain();

      // Reset in the middle of a load restores the reset table.
      cfg_begin();
      for (int i = 0; i < 9; i++) shift_bit(1'b1);
      rst = 1'b1;
      #1;
      chk("midload_rst_out_valid", 32'(ifc.out_valid), 32'd0);
      chk("midload_rst_eval_count", 32'(ifc.eval_count), 32'd0);
      chk("midload_rst_cfg_ready", 32'(ifc.cfg_ready), 32'd0);
      chk("midload_rst_cfg_done", 32'(ifc.cfg_done), 32'd0);
      exp_q.delete();
      cnt_model = 0;
      model_tt  = 16'hE93A;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int v = 0; v < 16; v++) send(4'(v), model_tt[v]);
      drain();
      chk("eval_count_model", 32'(ifc.eval_count), 32'(cnt_model));
      chk("eval_count_16", 32'(ifc.eval_count), 32'd16);

      // Small-counter instance: saturation and 2-input table.
      for (int k = 0; k < 5; k++) begin
         ifc2.in_vec   = 2'(vecs2[k]);
         ifc2.in_valid = 1'b1;
         @(posedge clk);
         #3;
         chk("dut2_out_valid", 32'(ifc2.out_valid), 32'd1);
         chk("dut2_out_bit", 32'(ifc2.out_bit), 32'(tt2_model[vecs2[k]]));
         chk("dut2_eval_count", 32'(ifc2.eval_count), (k + 1 > 3) ? 32'd3 : 32'(k + 1));
      end
      ifc2.in_valid = 1'b0;
      @(posedge clk);
      #3;
      chk("dut2_out_valid_clear", 32'(ifc2.out_valid), 32'd0);
      chk("dut2_eval_count_sat", 32'(ifc2.eval_count), 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/programmable_tt_eval.md
PROGRAMMABLE_TT_EVAL -- requirements
Module: programmable_tt_eval

Interface
REQ-001 Parameter N_IN, default 4: number of logic inputs, legal range 2..6.
REQ-002 Parameter TT_RESET, default 16'hE93A: truth table loaded at reset; width is 2**N_IN bits.
REQ-003 Parameter CNT_W, default 16: width of the evaluation counter.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous reset, active high.
REQ-006 cfg_start  input  1  single-cycle request to begin loading a new truth table.
REQ-007 cfg_abort  input  1  abandons a load in progress.
REQ-008 cfg_valid  input  1  cfg_bit is valid this cycle.
REQ-009 cfg_bit  input  1  serial truth-table bit, MSB (index 2**N_IN-1) first.
REQ-010 cfg_ready  output  1  block accepts cfg_bit this cycle.
REQ-011 cfg_done  output  1  one-cycle pulse when a complete table is committed.
REQ-012 in_valid  input  1  in_vec is valid this cycle.
REQ-013 in_vec  input  N_IN  input vector; in_vec[0] is the LSB of the table index.
REQ-014 in_ready  output  1  block accepts in_vec this cycle.
REQ-015 out_valid  output  1  out_bit holds a result.
REQ-016 out_bit  output  1  evaluated function value.
REQ-017 out_ready  input  1  downstream consumes out_bit this cycle.
REQ-018 eval_count  output  CNT_W  number of accepted evaluations, saturating.

Function
REQ-019 The FSM SHALL have two states: RUN and LOAD.
REQ-020 In RUN, cfg_start SHALL move the FSM to LOAD on the next cycle, clear the bit index, and leave the active table unchanged.
REQ-021 In LOAD, cfg_ready SHALL be 1; each cycle with cfg_valid=1 SHALL shift cfg_bit into the shadow register (shift-left) and increment the bit index.
REQ-022 When bit number 2**N_IN is accepted, the shadow register SHALL be copied to the active table, cfg_done SHALL pulse for the following cycle, and the FSM SHALL return to RUN.
REQ-023 cfg_abort in LOAD SHALL return the FSM to RUN, discard the shadow register, and keep the active table; cfg_abort takes priority over a cfg_bit accepted in the same cycle.
REQ-024 cfg_start in LOAD SHALL be ignored; cfg_abort in RUN SHALL be ignored.
REQ-025 in_ready SHALL be 1 only when the FSM is in RUN and (out_valid=0 or out_ready=1).
REQ-026 An accepted in_vec SHALL produce out_bit = active_table[in_vec] with out_valid=1 exactly one cycle later (latency 1), giving a full throughput of one result per cycle.
REQ-027 out_bit and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 out_valid SHALL clear after a cycle with out_ready=1 if no new input is accepted in that cycle.
REQ-029 A result already in the output register when LOAD begins SHALL remain valid and SHALL keep its old-table value.
REQ-030 eval_count SHALL increment on every accepted in_vec and SHALL saturate at 2**CNT_W-1.
REQ-031 cfg_ready SHALL be 0 in RUN, and cfg_done SHALL be 0 except for the commit pulse.

Reset
REQ-032 Asserting rst SHALL immediately set: FSM=RUN, active table=TT_RESET, shadow=0, bit index=0, out_valid=0, out_bit=0, cfg_done=0, eval_count=0.
REQ-033 rst asserted during LOAD SHALL discard the partial load; after reset the active table SHALL equal TT_RESET.

Structure
REQ-034 A shared package SHALL hold the FSM state enum (RUN, LOAD) and a function that returns the table width 2**N_IN.
REQ-035 Serial shadow loading (shift register, bit index, completion detect) SHALL be a sub-module named tt_shift_loader; the FSM, output pipeline, and counter remain in the top module.

Verification
REQ-036 Reset, then apply in_vec 0,1,3,15 with out_ready=1 -> out_bit 0,1,1,1 one cycle after each input; eval_count=4.
REQ-037 cfg_start, then shift 0x8000 MSB-first (16 bits) -> cfg_done pulses once; in_vec=15 gives 1, and in_vec 0..14 give 0.
REQ-038 Accept in_vec=1, hold out_ready=0 for 3 cycles -> out_valid=1, out_bit=1 stable, in_ready=0; out_ready=1 -> in_ready=1 in the same cycle.
REQ-039 cfg_start, 5 bits, cfg_abort -> FSM in RUN, no cfg_done; in_vec=0 gives 0 and in_vec=1 gives 1 (table still 0xE93A).
REQ-040 rst asserted after 9 of 16 load bits -> table 0xE93A; eval_count preset near 0xFFFF, 3 accepts -> eval_count=0xFFFF.
